// File: rtl/seq_alu.sv
// Registered ALU for the 8051-style datapath: single-cycle logic/arith ops plus
// iterative shift-add MUL and restoring DIV that hold busy for WIDTH cycles.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ans,
    output logic [WIDTH-1:0] ans_hi,
    output logic             c_out,
    output logic             ac_out,
    output logic             ov_out
);

    localparam logic [4:0] OP_ADD  = 5'h00, OP_ADDC = 5'h01, OP_INC  = 5'h02,
                           OP_DEC  = 5'h03, OP_SUBB = 5'h04, OP_MUL  = 5'h05,
                           OP_DIV  = 5'h06, OP_DA   = 5'h07, OP_ANL  = 5'h08,
                           OP_ORL  = 5'h09, OP_XRL  = 5'h0A, OP_SETB = 5'h0B,
                           OP_CLR  = 5'h0C, OP_CPL  = 5'h0D, OP_RL   = 5'h0E,
                           OP_RLC  = 5'h0F, OP_RR   = 5'h10, OP_RRC  = 5'h11,
                           OP_SWAP = 5'h12;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t           state;
    logic [WIDTH-1:0] opnd;   // multiplicand for MUL, divisor for DIV
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   ax, bx, add_r, sub_r;
    logic             add_ci;
    logic [7:0]       da_a, da_r;
    logic [8:0]       da_t1;
    logic             da_lo_adj, da_hi_adj;
    logic [WIDTH-1:0] s_ans;
    logic             s_c, s_ac, s_ov;

    always_comb begin
        ax        = {1'b0, a_data};
        bx        = {1'b0, b_data};
        add_ci    = (alu_op == OP_ADDC) && c_in;
        add_r     = ax + bx + {{WIDTH{1'b0}}, add_ci};
        sub_r     = ax - bx - {{WIDTH{1'b0}}, c_in};
        da_a      = 8'(a_data);
        da_lo_adj = (da_a[3:0] > 4'd9) || ac_out;
        da_t1     = {1'b0, da_a} + (da_lo_adj ? 9'd6 : 9'd0);
        da_hi_adj = (da_t1[7:4] > 4'd9) || c_in || da_t1[8];
        da_r      = da_t1[7:0] + (da_hi_adj ? 8'h60 : 8'h00);

        s_ans = '0;
        s_c   = c_out;
        s_ac  = ac_out;
        s_ov  = ov_out;
        case (alu_op)
            OP_ADD, OP_ADDC: begin
                s_ans = add_r[WIDTH-1:0];
                s_c   = add_r[WIDTH];
                // carry into bit 4 / into MSB recovered from sum ^ operands
                s_ac  = add_r[4] ^ ax[4] ^ bx[4];
                s_ov  = add_r[WIDTH] ^ add_r[WIDTH-1] ^ ax[WIDTH-1] ^ bx[WIDTH-1];
            end
            OP_SUBB: begin
                s_ans = sub_r[WIDTH-1:0];
                s_c   = sub_r[WIDTH];
                s_ac  = sub_r[4] ^ ax[4] ^ bx[4];
                s_ov  = (a_data[WIDTH-1] != b_data[WIDTH-1]) &&
                        (sub_r[WIDTH-1] != a_data[WIDTH-1]);
            end
            OP_INC:  s_ans = a_data + WIDTH'(1);
            OP_DEC:  s_ans = a_data - WIDTH'(1);
            OP_DA: begin
                if (WIDTH == 8) begin
                    s_ans = WIDTH'(da_r);
                    s_c   = da_hi_adj;
                end
            end
            OP_ANL:  s_ans = a_data & b_data;
            OP_ORL:  s_ans = a_data | b_data;
            OP_XRL:  s_ans = a_data ^ b_data;
            OP_SETB: s_ans = WIDTH'(1);
            OP_CLR:  s_ans = '0;
            OP_CPL:  s_ans = ~a_data;
            OP_RL:   s_ans = {a_data[WIDTH-2:0], a_data[WIDTH-1]};
            OP_RLC: begin
                s_ans = {a_data[WIDTH-2:0], c_in};
                s_c   = a_data[WIDTH-1];
            end
            OP_RR:   s_ans = {a_data[0], a_data[WIDTH-1:1]};
            OP_RRC: begin
                s_ans = {c_in, a_data[WIDTH-1:1]};
                s_c   = a_data[0];
            end
            OP_SWAP: s_ans = {a_data[WIDTH/2-1:0], a_data[WIDTH-1:WIDTH/2]};
            default: ;
        endcase
    end

    logic [WIDTH:0]   mul_sum, r_sh, r_diff;
    logic             q_bit;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             last;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        r_sh    = {hi, lo[WIDTH-1]};
        r_diff  = r_sh - {1'b0, opnd};
        q_bit   = ~r_diff[WIDTH];
        if (state == ST_DIV) begin
            hi_n = q_bit ? r_diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], q_bit};
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo[WIDTH-1:1]};
        end
        last = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ans    <= '0;
            ans_hi <= '0;
            c_out  <= 1'b0;
            ac_out <= 1'b0;
            ov_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (alu_op == OP_MUL || alu_op == OP_DIV) begin
                            opnd  <= (alu_op == OP_MUL) ? a_data : b_data;
                            lo    <= (alu_op == OP_MUL) ? b_data : a_data;
                            hi    <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= (alu_op == OP_MUL) ? ST_MUL : ST_DIV;
                        end else begin
                            ans    <= s_ans;
                            ans_hi <= '0;
                            c_out  <= s_c;
                            ac_out <= s_ac;
                            ov_out <= s_ov;
                            done   <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        ans    <= lo_n;
                        ans_hi <= hi_n;
                        c_out  <= 1'b0;
                        ov_out <= (state == ST_MUL) ? (|hi_n) : ~(|opnd);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table on an 8-bit instance, hand sequences
// for mid-busy start, async reset during MUL, and a 16-bit instance.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [4:0]  alu_op;
    logic [15:0] a_in, b_in;
    logic        c_in;

    logic        busy8, done8, c8, ac8, ov8;
    logic [7:0]  ans8, hi8;
    logic        busy16, done16, c16, ac16, ov16;
    logic [15:0] ans16, hi16;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .alu_op(alu_op),
        .a_data(a_in[7:0]), .b_data(b_in[7:0]), .c_in(c_in),
        .busy(busy8), .done(done8), .ans(ans8), .ans_hi(hi8),
        .c_out(c8), .ac_out(ac8), .ov_out(ov8)
    );

    seq_alu #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .alu_op(alu_op),
        .a_data(a_in), .b_data(b_in), .c_in(c_in),
        .busy(busy16), .done(done16), .ans(ans16), .ans_hi(hi16),
        .c_out(c16), .ac_out(ac16), .ov_out(ov16)
    );

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] ans;
        logic [7:0] hi;
        logic       c;
        logic       ac;
        logic       ov;
        int         lat;
    } vec_t;

    vec_t vt[30];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run(input bit wide, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, output int lat);
        @(negedge clk);
        alu_op = op; a_in = a; b_in = b; c_in = cin;
        if (wide) start16 = 1'b1;
        else      start8  = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        lat = 1;
        while (!(wide ? done16 : done8) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;

        //          op     a      b      ci    ans    hi     c     ac    ov   lat
        vt[0]  = '{5'h00, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[1]  = '{5'h04, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vt[2]  = '{5'h01, 8'h7F, 8'h80, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vt[3]  = '{5'h02, 8'hFF, 8'h55, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vt[4]  = '{5'h03, 8'h00, 8'h55, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1};
        vt[5]  = '{5'h05, 8'h50, 8'hA0, 1'b0, 8'h00, 8'h32, 1'b0, 1'b1, 1'b1, 9};
        vt[6]  = '{5'h08, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[7]  = '{5'h09, 8'hF0, 8'h0C, 1'b0, 8'hFC, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[8]  = '{5'h0A, 8'hFF, 8'h0F, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[9]  = '{5'h0B, 8'hAA, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[10] = '{5'h0C, 8'hAA, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[11] = '{5'h0D, 8'h5A, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[12] = '{5'h0E, 8'h81, 8'h00, 1'b0, 8'h03, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[13] = '{5'h0F, 8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 1'b1, 1'b1, 1'b1, 1};
        vt[14] = '{5'h10, 8'h01, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1};
        vt[15] = '{5'h11, 8'h02, 8'h00, 1'b1, 8'h81, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[16] = '{5'h12, 8'hA5, 8'h00, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[17] = '{5'h06, 8'hFB, 8'h12, 1'b0, 8'h0D, 8'h11, 1'b0, 1'b1, 1'b0, 9};
        vt[18] = '{5'h06, 8'h37, 8'h00, 1'b0, 8'hFF, 8'h37, 1'b0, 1'b1, 1'b1, 9};
        vt[19] = '{5'h1A, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[20] = '{5'h05, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b1, 9};
        vt[21] = '{5'h06, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 9};
        vt[22] = '{5'h00, 8'h49, 8'h38, 1'b0, 8'h81, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[23] = '{5'h07, 8'h81, 8'h00, 1'b0, 8'h87, 8'h00, 1'b0, 1'b1, 1'b1, 1};
        vt[24] = '{5'h00, 8'h99, 8'h99, 1'b0, 8'h32, 8'h00, 1'b1, 1'b1, 1'b1, 1};
        vt[25] = '{5'h07, 8'h32, 8'h00, 1'b1, 8'h98, 8'h00, 1'b1, 1'b1, 1'b1, 1};
        vt[26] = '{5'h00, 8'h01, 8'h01, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1};
        vt[27] = '{5'h07, 8'h9A, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1};
        vt[28] = '{5'h04, 8'h10, 8'h01, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 1};
        vt[29] = '{5'h1F, 8'hC3, 8'h3C, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1};

        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        alu_op = '0; a_in = '0; b_in = '0; c_in = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset8",  {busy8, done8, c8, ac8, ov8, ans8, hi8}, 0);
        chk("reset16", {busy16, done16, c16, ac16, ov16}, 0);
        chk("reset16 ans", {ans16, hi16}, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            run(1'b0, vt[i].op, {8'h00, vt[i].a}, {8'h00, vt[i].b}, vt[i].cin, lat);
            chk($sformatf("v%0d lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d ans", i), ans8, vt[i].ans);
            chk($sformatf("v%0d ans_hi", i), hi8, vt[i].hi);
            chk($sformatf("v%0d c_out", i), c8, vt[i].c);
            chk($sformatf("v%0d ac_out", i), ac8, vt[i].ac);
            chk($sformatf("v%0d ov_out", i), ov8, vt[i].ov);
            @(posedge clk); #1;
            chk($sformatf("v%0d done one-shot", i), done8, 0);
        end

        // MUL 3*5 with operands changed after issue and a start pulse while busy
        @(negedge clk);
        alu_op = 5'h05; a_in = 16'h0003; b_in = 16'h0005; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a_in = 16'h00FF; b_in = 16'h00FF;
        lat = 1; bcnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            if (lat == 3) begin alu_op = 5'h00; start8 = 1'b1; end
            else start8 = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b0;
        chk("midbusy lat", lat, 9);
        chk("midbusy busy cycles", bcnt, 8);
        chk("midbusy ans", ans8, 8'h0F);
        chk("midbusy ans_hi", hi8, 8'h00);
        chk("midbusy ov_out", ov8, 0);
        chk("midbusy busy low", busy8, 0);
        @(posedge clk); #1;
        chk("midbusy no extra done", done8, 0);

        // async reset three cycles into a MUL
        @(negedge clk);
        alu_op = 5'h05; a_in = 16'h0050; b_in = 16'h00A0; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        chk("busy before rst", busy8, 1);
        rst = 1'b1; #1;
        chk("async rst outputs", {busy8, done8, c8, ac8, ov8, ans8, hi8}, 0);
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dcnt++;
        end
        chk("no done after rst", dcnt, 0);
        run(1'b0, 5'h00, 16'h007F, 16'h0001, 1'b0, lat);
        chk("post-rst lat", lat, 1);
        chk("post-rst ans", ans8, 8'h80);
        chk("post-rst flags", {c8, ac8, ov8}, 3'b011);

        // 16-bit instance
        run(1'b1, 5'h05, 16'hFFFF, 16'hFFFF, 1'b0, lat);
        chk("w16 mul lat", lat, 17);
        chk("w16 mul ans", ans16, 16'h0001);
        chk("w16 mul ans_hi", hi16, 16'hFFFE);
        chk("w16 mul c/ov", {c16, ov16}, 2'b01);
        run(1'b1, 5'h12, 16'h1234, 16'h0000, 1'b0, lat);
        chk("w16 swap ans", ans16, 16'h3412);
        chk("w16 swap ans_hi", hi16, 16'h0000);
        chk("w16 swap lat", lat, 1);
        run(1'b1, 5'h1A, 16'h5555, 16'hAAAA, 1'b0, lat);
        chk("w16 illegal lat", lat, 1);
        chk("w16 illegal ans", ans16, 16'h0000);
        chk("w16 illegal flags held", {c16, ov16}, 2'b01);
        run(1'b1, 5'h00, 16'h8000, 16'h8000, 1'b0, lat);
        chk("w16 add ans", ans16, 16'h0000);
        chk("w16 add flags", {c16, ac16, ov16}, 3'b101);
        run(1'b1, 5'h07, 16'h0099, 16'h0000, 1'b0, lat);
        chk("w16 da ans", ans16, 16'h0000);
        chk("w16 da flags held", {c16, ac16, ov16}, 3'b101);
        chk("w16 da lat", lat, 1);
        run(1'b1, 5'h06, 16'h1234, 16'h0010, 1'b0, lat);
        chk("w16 div lat", lat, 17);
        chk("w16 div ans", ans16, 16'h0123);
        chk("w16 div ans_hi", hi16, 16'h0004);
        chk("w16 div c/ov", {c16, ov16}, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 8051 core's combinational ALU.
- Single-cycle ops use the existing 5-bit opcode map. MUL is an iterative shift-add and DIV an iterative restoring divide, each taking WIDTH cycles.
- Produces a full PSW flag set (CY, AC, OV) and a high/remainder result for MUL AB / DIV AB.
- Sits between the decoder/sequencer and the ACC/B/PSW write-back; the sequencer stalls on busy.

Parameters:
- WIDTH, 8, data width in bits; must be even and >= 4. DA is defined only for WIDTH=8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  issue request; sampled only in IDLE
- alu_op  input  5  opcode (map below)
- a_data  input  WIDTH  operand A (ACC)
- b_data  input  WIDTH  operand B
- c_in  input  1  PSW.CY in
- busy  output  1  high while MUL/DIV iterates
- done  output  1  one-cycle pulse: results valid and updated
- ans  output  WIDTH  result (MUL low half / DIV quotient)
- ans_hi  output  WIDTH  MUL high half / DIV remainder; 0 for other ops
- c_out  output  1  CY flag
- ac_out  output  1  AC flag
- ov_out  output  1  OV flag

Behaviour:
- Opcode map:
  - 0 ADD, 1 ADDC, 2 INC, 3 DEC, 4 SUBB, 5 MUL, 6 DIV, 7 DA
  - 8 ANL, 9 ORL, A XRL, B SETB (ans=1), C CLR (ans=0), D CPL
  - E RL, F RLC, 10 RR, 11 RRC, 12 SWAP
  - 13-1F illegal
- Reset: asynchronous; takes effect immediately regardless of state.
  - State returns to IDLE.
  - busy, done, ans, ans_hi, c_out, ac_out and ov_out all go to 0.
  - An in-flight MUL/DIV is abandoned with no done pulse.
- States:
  - IDLE: on start with op != 5/6, register the result; done=1 in the next cycle (latency 1), state stays IDLE. Back-to-back starts give back-to-back done pulses.
  - IDLE -> MUL on start with op=5; IDLE -> DIV on start with op=6. Operands are latched, counter cleared, busy=1 from the next cycle.
  - MUL/DIV: one bit per cycle for WIDTH cycles. Then go to IDLE, busy=0, done=1 in the same cycle as the result update. Latency from start to done is WIDTH+1 cycles.
  - start is ignored while busy. Operand inputs may change after the start cycle without effect.
- Outputs are registered and hold their values between done pulses.
- Flags not affected by an op hold their previous values (8051 semantics), except that ans_hi is cleared by every non-MUL/DIV op.
- ADD/ADDC:
  - c_out = carry out of bit WIDTH-1.
  - ac_out = carry out of bit 3.
  - ov_out = signed overflow (carry into MSB xor carry out of MSB).
- SUBB computes a-b-c_in.
  - c_out = borrow out of MSB; ac_out = borrow out of bit 3.
  - ov_out = signed overflow.
- INC/DEC: wrap modulo 2^WIDTH; no flags changed.
- RLC/RRC: c_out = the bit shifted out; c_in is shifted in.
- SWAP: exchanges the WIDTH/2-bit halves.
- MUL: {ans_hi,ans} = a*b, full 2*WIDTH-bit product. c_out=0; ov_out=1 iff ans_hi != 0.
- DIV: ans=a/b, ans_hi=a%b, c_out=0, ov_out=0.
  - Divide by zero: completes with the same latency; ans=all-ones, ans_hi=a, ov_out=1, c_out=0.
- DA (WIDTH=8):
  - If low nibble > 9 or ac_out (current PSW.AC register) is set, add 6.
  - Then if the high value > 9 or c_in is set, or that step carried, add 0x60 and set c_out. Otherwise c_out = c_in.
- Illegal ops, and DA when WIDTH != 8: ans=0, ans_hi=0, flags unchanged; done still pulses.

Test Plan:
- ADD, a=8'h7F b=8'h01 -> next cycle done=1, ans=80, c_out=0, ac_out=1, ov_out=1. SUBB a=00 b=00 c_in=1 -> ans=FF, c_out=1, ac_out=1, ov_out=0.
- MUL, a=8'h50 b=8'hA0 -> busy for 8 cycles, done at cycle 9, ans=00, ans_hi=32, ov_out=1, c_out=0. Start pulsed mid-busy is ignored.
- DIV, a=8'hFB b=8'h12 -> quotient 0D, remainder 11, ov_out=0. DIV with b=0 and a=8'h37 -> ans=FF, ans_hi=37, ov_out=1.
- ADD 49+38 (ans=81, AC=1), then DA -> ans=87, c_out=0. ADD 99+99 (ans=32, CY=1, AC=1), then DA -> ans=98, c_out=1.
- Assert rst 3 cycles into a MUL -> all outputs 0 immediately, no done. A new ADD issued after release works normally.
- WIDTH=16 build: MUL FFFF*FFFF -> ans=0001, ans_hi=FFFE, latency 17. SWAP 1234 -> 3412. Illegal op 5'h1A -> ans=0 and done pulses.
